// File: rtl/redmule_tcdm_responder.sv
// Synthesizable TCDM memory responder for the RedMulE streamer wide port.
// Serves DW-bit accesses from a 32-bit word array with a bounded, in-order response queue.
module redmule_tcdm_responder #(
  parameter int unsigned DW         = 288,
  parameter int unsigned UW         = 1,
  parameter int unsigned AW         = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            stall_en_i,
  input  logic            tcdm_req_i,
  output logic            tcdm_gnt_o,
  input  logic [AW-1:0]   tcdm_add_i,
  input  logic            tcdm_wen_i,
  input  logic [DW/8-1:0] tcdm_be_i,
  input  logic [DW-1:0]   tcdm_data_i,
  input  logic [UW-1:0]   tcdm_user_i,
  output logic [DW-1:0]   tcdm_r_data_o,
  output logic            tcdm_r_valid_o,
  input  logic            tcdm_r_ready_i,
  output logic [UW-1:0]   tcdm_r_user_o,
  output logic            tcdm_r_opc_o
);

  localparam int unsigned NL = DW / 32;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [31:0]    mem_q [DEPTH];
  logic [IW-1:0]  lane_idx [NL];
  logic [DW-1:0]  rd_data;

  logic [15:0]    lfsr_q;
  logic           stall;

  logic           out_valid_q;
  logic [DW-1:0]  out_data_q;
  logic [UW-1:0]  out_user_q;

  logic [DW-1:0]  fifo_data_q [RESP_DEPTH];
  logic [UW-1:0]  fifo_user_q [RESP_DEPTH];
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  fifo_cnt_q;
  logic [CW-1:0]  outstanding;

  logic pop, room, gnt, wr_en, rd_en, load_out, fifo_pop, fifo_push;
  logic unused_add;

  assign unused_add = ^{tcdm_add_i[AW-1:IW+2], tcdm_add_i[1:0]};

  // Lane k of the access hits word base+k; the IW-bit sum wraps at the top of the array.
  always_comb begin
    for (int k = 0; k < NL; k++) begin
      lane_idx[k] = tcdm_add_i[IW+1:2] + IW'(k);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NL; k++) begin
      rd_data[32*k +: 32] = mem_q[lane_idx[k]];
    end
  end

  assign stall       = stall_en_i & (lfsr_q[1:0] == 2'b00);
  assign outstanding = CW'(out_valid_q) + fifo_cnt_q;
  assign pop         = out_valid_q & tcdm_r_ready_i;
  // A pop frees a slot in the same cycle, so a read may be granted alongside it.
  assign room        = (outstanding < CW'(RESP_DEPTH)) | pop;
  assign gnt         = rst_ni & tcdm_req_i & ~stall & ~clear_i & (~tcdm_wen_i | room);
  assign wr_en       = gnt & ~tcdm_wen_i;
  assign rd_en       = gnt & tcdm_wen_i;
  assign load_out    = ~out_valid_q | pop;
  assign fifo_pop    = load_out & (fifo_cnt_q != '0);
  assign fifo_push   = rd_en & ~(load_out & (fifo_cnt_q == '0));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < NL; k++) begin
        for (int b = 0; b < 4; b++) begin
          if (tcdm_be_i[4*k+b]) mem_q[lane_idx[k]][8*b +: 8] <= tcdm_data_i[32*k+8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_user_q[wr_ptr_q] <= tcdm_user_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q      <= LFSR_SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else if (clear_i) begin
      lfsr_q      <= LFSR_SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      // The output register holds the queue head; data is left untouched when it empties.
      if (load_out) begin
        if (fifo_cnt_q != '0) begin
          out_valid_q <= 1'b1;
          out_data_q  <= fifo_data_q[rd_ptr_q];
          out_user_q  <= fifo_user_q[rd_ptr_q];
        end else if (rd_en) begin
          out_valid_q <= 1'b1;
          out_data_q  <= rd_data;
          out_user_q  <= tcdm_user_i;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (fifo_push && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + CW'(1);
      else if (!fifo_push && fifo_pop) fifo_cnt_q <= fifo_cnt_q - CW'(1);
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = out_valid_q;
  assign tcdm_r_data_o  = out_data_q;
  assign tcdm_r_user_o  = out_user_q;
  assign tcdm_r_opc_o   = 1'b0;

endmodule
